// File: rtl/rom_loader.sv
// Byte-stream ROM loader: 4-byte LE word count, then N LE words written at consecutive addresses; CPU held in reset while busy.
// Write strobe one cycle after a word's 4th byte; byte_ready_o drops in IDLE/WRITE/DONE. Optional idle timeout: ROM_LOADER_TIMEOUT_EN.
module rom_loader #(
  parameter int unsigned ROM_DEPTH      = 4096,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        rom_wr_en_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] DEPTH_W = 32'(ROM_DEPTH);

  logic [2:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        wr_en_q, wr_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;
  logic [31:0] asm_word;

`ifdef ROM_LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`endif

  assign accept   = byte_valid_i && ready_q;
  // Bytes shift in from the top, so after four bytes the first one sits in [7:0].
  assign asm_word = {byte_i, data_q[31:8]};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (load_req_i) begin
          state_d    = S_LEN;
          err_d      = 1'b0;
          addr_d     = BASE_ADDR;
          byte_cnt_d = 2'd0;
          word_cnt_d = 32'd0;
          data_d     = 32'd0;
        end
      end
      S_LEN, S_DATA: begin
        if (accept) begin
          data_d     = asm_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_DATA) begin
              state_d = S_WRITE;
            end else begin
              len_d = asm_word;
              if (asm_word > DEPTH_W) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end else if (asm_word == 32'd0) begin
                state_d = S_DONE;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
      end
      S_WRITE: begin
        addr_d     = addr_q + 32'd4;
        word_cnt_d = word_cnt_q + 32'd1;
        state_d    = (word_cnt_d == len_q) ? S_DONE : S_DATA;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef ROM_LOADER_TIMEOUT_EN
    tmo_d = 32'd0;
    if ((state_q == S_LEN || state_q == S_DATA) && !accept) begin
      tmo_d = tmo_q + 32'd1;
      if (tmo_d >= 32'(TIMEOUT_CYCLES)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        tmo_d   = 32'd0;
      end
    end
`endif

    // Every status output is a registered decode of the next state.
    ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    wr_en_d = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 32'd0;
      len_q      <= 32'd0;
      addr_q     <= BASE_ADDR;
      data_q     <= 32'd0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef ROM_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= 32'd0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign byte_ready_o = ready_q;
  assign rom_wr_en_o  = wr_en_q;
  assign rom_addr_o   = addr_q;
  assign rom_data_o   = data_q;
  assign cpu_hold_o   = busy_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized scoreboard bench for rom_loader: expected ROM writes and done pulses are queued at stimulus time and popped by a monitor.
module tb_rom_loader;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        rom_wr_en_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  rom_loader #(
    .ROM_DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_req_i(load_req_i),
    .byte_valid_i(byte_valid_i),
    .byte_i(byte_i),
    .byte_ready_o(byte_ready_o),
    .rom_wr_en_o(rom_wr_en_o),
    .rom_addr_o(rom_addr_o),
    .rom_data_o(rom_data_o),
    .cpu_hold_o(cpu_hold_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] wq[$];
  int          exp_done = 0;
  int          checks   = 0;
  int          passed   = 0;
  bit          mon_en   = 1'b0;
  bit          prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got %h, required none", name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_done) begin
        check("hold_after_done", 32'(cpu_hold_o), 32'd0);
        check("busy_after_done", 32'(busy_o), 32'd0);
      end
      prev_done = done_o;
      if (rom_wr_en_o) begin
        check("ready_in_write", 32'(byte_ready_o), 32'd0);
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write", rom_addr_o);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("write_addr", rom_addr_o, e.addr);
          check("write_data", rom_data_o, e.data);
        end
      end
      if (done_o) begin
        check("ready_in_done", 32'(byte_ready_o), 32'd0);
        check("err_at_done", 32'(err_o), 32'd0);
        if (exp_done == 0) fail_now("unexpected_done", 32'd1);
        else exp_done--;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while ($urandom_range(0, 3) == 0) begin
      byte_valid_i = 1'b0;
      byte_i       = 8'($urandom);
      load_req_i   = busy_o && ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    byte_valid_i = 1'b1;
    byte_i       = b;
    while (!byte_ready_o && guard < 20) begin
      load_req_i = busy_o && ($urandom_range(0, 5) == 0);
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) fail_now("byte_accept_timeout", 32'(b));
    load_req_i = busy_o && ($urandom_range(0, 5) == 0);
    @(negedge clk);
    byte_valid_i = 1'b0;
    load_req_i   = 1'b0;
  endtask

  task automatic start_load();
    load_req_i = 1'b1;
    @(negedge clk);
    load_req_i = 1'b0;
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_hold", 32'(cpu_hold_o), 32'd1);
    check("start_ready", 32'(byte_ready_o), 32'd1);
    check("start_err_clear", 32'(err_o), 32'd0);
    check("start_addr", rom_addr_o, BASE);
  endtask

  // Reference: length N is LE; N > DEPTH aborts with error, else word i lands at BASE + 4*i.
  task automatic run_load(input logic [31:0] n);
    logic [31:0] w;
    bit ok;
    int g = 0;
    ok = (n <= DEPTH);
    start_load();
    if (ok) begin
      for (int i = 0; i < int'(n); i++) exp_wr.push_back({BASE + 32'(4 * i), wq[i]});
      exp_done++;
    end
    for (int k = 0; k < 4; k++) begin
      w = n >> (8 * k);
      send_byte(w[7:0]);
    end
    if (!ok) begin
      check("oversize_err", 32'(err_o), 32'd1);
      check("oversize_busy", 32'(busy_o), 32'd0);
      check("oversize_hold", 32'(cpu_hold_o), 32'd0);
      check("oversize_ready", 32'(byte_ready_o), 32'd0);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      for (int k = 0; k < 4; k++) begin
        w = wq[i] >> (8 * k);
        send_byte(w[7:0]);
      end
    end
    while (busy_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) fail_now("load_finish_timeout", 32'(g));
    check("writes_drained", 32'(exp_wr.size()), 32'd0);
    check("done_seen", 32'(exp_done), 32'd0);
    check("err_after_load", 32'(err_o), 32'd0);
    check("hold_after_load", 32'(cpu_hold_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    check({tag, "_wr_en"}, 32'(rom_wr_en_o), 32'd0);
    check({tag, "_addr"}, rom_addr_o, BASE);
    check({tag, "_data"}, rom_data_o, 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  task automatic fill_wq(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  initial begin
    rst_n        = 1'b0;
    load_req_i   = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    wq.delete();
    wq.push_back(32'h0010_0513);
    wq.push_back(32'h0000_006F);
    run_load(32'd2);

    run_load(32'd0);
    run_load(32'd5);
    run_load(32'h0100_0002);
    fill_wq(4);
    run_load(32'd4);

    // Abort after 6 bytes (length + 2 data bytes), then reload from BASE.
    fill_wq(3);
    start_load();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    exp_wr.delete();
    exp_done  = 0;
    prev_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_wq(2);
    run_load(32'd2);

    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(0, 6);
      fill_wq(n);
      run_load(32'(n));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d checks, required completion", checks);
    $fatal(1);
  end

endmodule
